load_writeback_unit: RTL
========================

// Module: load_writeback_unit
// PURPOSE
//  Multi-cycle load stage that feeds the register-file write port (waddr/wen/wdata).
//  Issues one word read to data memory, waits on a ready handshake, then aligns,
//  extends and byte-masks the result for MIPS LB/LBU/LH/LHU/LW/LWL/LWR.
//  LWL/LWR merging relies on the register file's per-byte write enables.
//  Sits between the execute stage (address + dest) and the register file.
// PARAMETERS
//  RF_ADDR_WIDTH  5    register-file address width (rf_waddr, dest)
//  MAX_WAIT       255  cycles to wait for mem_ready before bus-error abort; 0 = wait forever
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  rst         in   1   synchronous reset, active-high
//  start       in   1   launch a load; sampled only when busy=0
//  op          in   3   MIPS opcode[2:0]: 000 LB,001 LH,010 LWL,011 LW,100 LBU,101 LHU,110 LWR,111 illegal
//  addr        in   32  byte address of the load
//  dest        in   RF_ADDR_WIDTH  destination register number
//  busy        out  1   high in every state except IDLE
//  mem_req     out  1   memory read request
//  mem_addr    out  32  word address {addr[31:2],2'b00}; 0 when mem_req=0
//  mem_ready   in   1   memory response valid this cycle (rdata valid)
//  mem_rdata   in   32  read word, little-endian (byte0 = [7:0])
//  rf_waddr    out  RF_ADDR_WIDTH  register-file write address
//  rf_wen      out  4   register-file per-byte write enable
//  rf_wdata    out  32  register-file write data
//  done        out  1   one-cycle pulse: operation finished (written or excepted)
//  exc         out  1   one-cycle pulse with done: 01 misaligned/illegal, see exc_code
//  exc_code    out  2   01 address error, 10 illegal op, 11 bus timeout; valid when exc=1
// BEHAVIOUR
//  Reset: state=IDLE; busy,mem_req,done,exc=0; mem_addr,rf_waddr,rf_wen,rf_wdata,exc_code=0.
//  Reset mid-operation aborts immediately: no write, no done, mem_req drops next edge.
//  States: IDLE -> REQ -> WB -> IDLE; IDLE -> ERR -> IDLE.
//  IDLE: start=1 latches op,addr,dest. Misaligned (LH/LHU addr[0]=1; LW addr[1:0]!=0)
//    or op=111 -> ERR; else -> REQ. start while busy=1 is ignored.
//  REQ: mem_req=1, mem_addr stable. mem_ready=1 latches mem_rdata -> WB. Wait counter
//    clears on entry, +1 per cycle without ready; reaching MAX_WAIT (MAX_WAIT!=0) -> ERR code 11.
//  WB (exactly 1 cycle): rf_waddr=dest, rf_wen/rf_wdata per table, done=1 -> IDLE.
//  ERR (exactly 1 cycle): rf_wen=0, done=1, exc=1, exc_code set -> IDLE. No mem_req ever for 01/10.
//  rf_wen=0 and rf_wdata=0 in every state except WB; dest=0 forces rf_wen=0 in WB (done still 1).
//  Latency: start@T, ready@T+1 -> write@T+2, done@T+2; each extra wait cycle adds 1.
//  Alignment, k=addr[1:0], B=byte k of word, H=halfword k[1]:
//    LB/LBU: wen 1111, sign/zero-extend B.  LH/LHU: wen 1111, sign/zero-extend H.
//    LW: wen 1111, word.  LWL: wdata=rdata<<8*(3-k), wen bits 3..3-k set.
//    LWR: wdata=rdata>>8*k, wen bits 0..3-k set.
//  Next start may be accepted in the IDLE cycle after done (back-to-back period 3 cycles min).
// TESTING
//  Reset, then idle 5 cycles -> all outputs 0, mem_req never asserted.
//  LB addr=0x1003, rdata=0x80FF_1234, ready next cycle, dest=7 -> rf_wen=1111, rf_wdata=0xFFFF_FF80, done@T+2.
//  LWL k=1 rdata=0xAABBCCDD -> wen 1100, wdata=0xCCDD0000; LWR k=1 -> wen 0111, wdata=0x00AABBCC.
//  LW addr=0x1002 -> no mem_req, ERR cycle: done=1, exc=1, exc_code=01, rf_wen=0; op=111 -> exc_code=10.
//  MAX_WAIT=4, mem_ready held 0 -> after 4 REQ cycles ERR with exc_code=11, mem_req drops.
//  rst asserted during REQ wait, then ready pulse -> no write, no done; LBU to dest=0 -> done=1, rf_wen=0.

Source files
------------

// File: rtl/load_writeback_unit.sv
// load_writeback_unit: multi-cycle MIPS load stage driving the register-file write port.
// Issues one aligned word read, waits for mem_ready (optionally bounded), then
// aligns/extends/byte-masks the word for LB/LBU/LH/LHU/LW/LWL/LWR.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start/op/addr/dest  load request from execute (sampled only when idle)
//   busy                high whenever not idle
//   mem_req/mem_addr    word read request to data memory
//   mem_ready/mem_rdata memory response
//   rf_waddr/rf_wen/rf_wdata  register-file write port (per-byte enables)
//   done/exc/exc_code   completion pulse, exception flag and cause
module load_writeback_unit #(
    parameter int unsigned RF_ADDR_WIDTH = 5,
    parameter int unsigned MAX_WAIT      = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [31:0]              addr,
    input  logic [RF_ADDR_WIDTH-1:0] dest,
    output logic                     busy,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ready,
    input  logic [31:0]              mem_rdata,
    output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
    output logic [3:0]               rf_wen,
    output logic [31:0]              rf_wdata,
    output logic                     done,
    output logic                     exc,
    output logic [1:0]               exc_code
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    // Counter value on the last permitted wait cycle (unused when MAX_WAIT is 0).
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LWL = 3'b010;
    localparam logic [2:0] OP_LW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_LWR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam logic [1:0] EXC_ADDR    = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               op_q, op_d;
    logic [31:0]              addr_q, addr_d;
    logic [RF_ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;

    logic                     busy_q, busy_d;
    logic                     mem_req_q, mem_req_d;
    logic [31:0]              mem_addr_q, mem_addr_d;
    logic [RF_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [3:0]               rf_wen_q, rf_wen_d;
    logic [31:0]              rf_wdata_q, rf_wdata_d;
    logic                     done_q, done_d;
    logic                     exc_q, exc_d;
    logic [1:0]               exc_code_q, exc_code_d;

    // Alignment datapath, evaluated on the response word as it arrives.
    logic [1:0]  k;
    logic [31:0] shr_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] algn_data;
    logic [3:0]  algn_wen;
    logic        illegal_c;
    logic        misalign_c;
    logic        timeout_c;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'b000;
            addr_q     <= 32'd0;
            dest_q     <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            rf_waddr_q <= '0;
            rf_wen_q   <= 4'd0;
            rf_wdata_q <= 32'd0;
            done_q     <= 1'b0;
            exc_q      <= 1'b0;
            exc_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            dest_q     <= dest_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wen_q   <= rf_wen_d;
            rf_wdata_q <= rf_wdata_d;
            done_q     <= done_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
        end
    end

    // Byte/halfword selection and LWL/LWR merge masks.
    always_comb begin
        k         = addr_q[1:0];
        shr_word  = mem_rdata >> {k, 3'b000};
        byte_sel  = shr_word[7:0];
        half_sel  = k[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        algn_data = 32'd0;
        algn_wen  = 4'b1111;
        case (op_q)
            OP_LB:   algn_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  algn_data = {24'd0, byte_sel};
            OP_LH:   algn_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  algn_data = {16'd0, half_sel};
            OP_LW:   algn_data = mem_rdata;
            // LWL fills the upper bytes; 3-k is ~k for a 2-bit k.
            OP_LWL: begin
                algn_data = mem_rdata << {~k, 3'b000};
                algn_wen  = 4'b1111 << ~k;
            end
            OP_LWR: begin
                algn_data = shr_word;
                algn_wen  = 4'b1111 >> k;
            end
            default: begin
                algn_data = 32'd0;
                algn_wen  = 4'b0000;
            end
        endcase
    end

    // Request checks and wait timeout.
    always_comb begin
        illegal_c  = (op == OP_ILL);
        misalign_c = ((op[1:0] == 2'b01) && addr[0]) ||
                     ((op == OP_LW) && (addr[1:0] != 2'b00));
        timeout_c  = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        dest_d     = dest_q;
        wait_d     = wait_q;
        busy_d     = 1'b0;
        mem_req_d  = 1'b0;
        mem_addr_d = 32'd0;
        rf_waddr_d = '0;
        rf_wen_d   = 4'd0;
        rf_wdata_d = 32'd0;
        done_d     = 1'b0;
        exc_d      = 1'b0;
        exc_code_d = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    addr_d = addr;
                    dest_d = dest;
                    busy_d = 1'b1;
                    if (illegal_c || misalign_c) begin
                        state_d    = ST_ERR;
                        done_d     = 1'b1;
                        exc_d      = 1'b1;
                        exc_code_d = illegal_c ? EXC_ILLEGAL : EXC_ADDR;
                    end else begin
                        state_d    = ST_REQ;
                        wait_d     = '0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {addr[31:2], 2'b00};
                    end
                end
            end
            ST_REQ: begin
                busy_d = 1'b1;
                if (mem_ready) begin
                    state_d    = ST_WB;
                    done_d     = 1'b1;
                    rf_waddr_d = dest_q;
                    rf_wdata_d = algn_data;
                    // Register 0 is never written, but the load still completes.
                    rf_wen_d   = (dest_q == '0) ? 4'd0 : algn_wen;
                end else if (timeout_c) begin
                    state_d    = ST_ERR;
                    done_d     = 1'b1;
                    exc_d      = 1'b1;
                    exc_code_d = EXC_TIMEOUT;
                end else begin
                    wait_d     = wait_q + WAIT_W'(1);
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr_q[31:2], 2'b00};
                end
            end
            ST_WB:   state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wen   = rf_wen_q;
    assign rf_wdata = rf_wdata_q;
    assign done     = done_q;
    assign exc      = exc_q;
    assign exc_code = exc_code_q;

endmodule
